// File: rtl/key_digit_entry.sv
// Keypad-to-display digit entry buffer: right-to-left accumulation, clear, backspace, operators.
// Optional KDE_LZ_BLANK_EN: blank leading display positions instead of showing leading zeros.
module key_digit_entry #(
    parameter int NUM_DIGITS = 8,
    parameter bit HEX_MODE   = 1'b0,
    localparam int CNT_W     = $clog2(NUM_DIGITS + 1)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [15:0]             key_pulse,
    input  logic                    clr,
    output logic [4*NUM_DIGITS-1:0] digits,
    output logic [NUM_DIGITS-1:0]   digit_en,
    output logic [CNT_W-1:0]        count,
    output logic                    op_valid,
    output logic [3:0]              op_code,
    output logic [4*NUM_DIGITS-1:0] op_value,
    output logic                    overflow
);
    typedef enum logic [1:0] {S_EMPTY, S_ENTRY, S_FULL, S_PENDING} state_t;

    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(NUM_DIGITS);

    state_t                  r_state, w_state_nx;
    logic [4*NUM_DIGITS-1:0] r_digits, w_digits_nx;
    logic [CNT_W-1:0]        r_count, w_count_nx;
    logic                    r_op_valid, w_op_valid_nx;
    logic [3:0]              r_op_code, w_op_code_nx;
    logic [4*NUM_DIGITS-1:0] r_op_value, w_op_value_nx;
    logic                    r_overflow, w_overflow_nx;

    logic [3:0] w_code;
    logic       w_one, w_is_digit, w_is_clr, w_is_bs, w_is_op;

    // Bit index i maps to code (i+1) mod 16; truncation to 4 bits does the wrap.
    always_comb begin
        w_code = 4'd0;
        for (int i = 0; i < 16; i++)
            if (key_pulse[i]) w_code = 4'(i + 1);
        w_one = (key_pulse != 16'd0) && ((key_pulse & (key_pulse - 16'd1)) == 16'd0);
    end

    assign w_is_digit = w_one && (HEX_MODE || (w_code <= 4'd9));
    assign w_is_clr   = w_one && !HEX_MODE && (w_code == 4'hC);
    assign w_is_bs    = w_one && !HEX_MODE && (w_code == 4'hD);
    assign w_is_op    = w_one && !HEX_MODE &&
                        (w_code == 4'hA || w_code == 4'hB || w_code == 4'hE || w_code == 4'hF);

    always_comb begin
        w_state_nx    = r_state;
        w_digits_nx   = r_digits;
        w_count_nx    = r_count;
        w_op_valid_nx = 1'b0;
        w_op_code_nx  = r_op_code;
        w_op_value_nx = r_op_value;
        w_overflow_nx = 1'b0;
        if (clr || w_is_clr) begin
            w_digits_nx = '0;
            w_count_nx  = '0;
            w_state_nx  = S_EMPTY;
        end else if (w_is_op) begin
            w_op_valid_nx = 1'b1;
            w_op_code_nx  = w_code;
            w_op_value_nx = r_digits;
            w_state_nx    = S_PENDING;
        end else if (w_is_digit) begin
            case (r_state)
                S_EMPTY, S_PENDING: begin
                    // A new number after an operator starts from a clean buffer.
                    w_digits_nx = '0;
                    w_count_nx  = '0;
                    w_state_nx  = S_EMPTY;
                    if (w_code != 4'd0) begin
                        w_digits_nx[3:0] = w_code;
                        w_count_nx       = CNT_W'(1);
                        w_state_nx       = (NUM_DIGITS == 1) ? S_FULL : S_ENTRY;
                    end
                end
                S_ENTRY: begin
                    w_digits_nx      = r_digits << 4;
                    w_digits_nx[3:0] = w_code;
                    w_count_nx       = r_count + CNT_W'(1);
                    w_state_nx       = (w_count_nx == FULL_CNT) ? S_FULL : S_ENTRY;
                end
                default: w_overflow_nx = 1'b1;
            endcase
        end else if (w_is_bs && (r_state == S_ENTRY || r_state == S_FULL)) begin
            w_digits_nx = r_digits >> 4;
            w_count_nx  = r_count - CNT_W'(1);
            w_state_nx  = (r_count == CNT_W'(1)) ? S_EMPTY : S_ENTRY;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_EMPTY;
            r_digits   <= '0;
            r_count    <= '0;
            r_op_valid <= 1'b0;
            r_op_code  <= 4'd0;
            r_op_value <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_state    <= w_state_nx;
            r_digits   <= w_digits_nx;
            r_count    <= w_count_nx;
            r_op_valid <= w_op_valid_nx;
            r_op_code  <= w_op_code_nx;
            r_op_value <= w_op_value_nx;
            r_overflow <= w_overflow_nx;
        end
    end

`ifdef KDE_LZ_BLANK_EN
    // Digits hold through PENDING, so r_count still describes op_value there.
    always_comb begin
        digit_en = '0;
        for (int i = 0; i < NUM_DIGITS; i++)
            digit_en[i] = (i == 0) || (CNT_W'(i) < r_count);
    end
`else
    assign digit_en = '1;
`endif

    assign digits   = r_digits;
    assign count    = r_count;
    assign op_valid = r_op_valid;
    assign op_code  = r_op_code;
    assign op_value = r_op_value;
    assign overflow = r_overflow;
endmodule

// File: tb/tb_key_digit_entry.sv
// Directed table-driven bench for key_digit_entry (decimal N=8 and hex N=8 instances).
module tb_key_digit_entry;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] key_pulse = '0, hkey = '0;
    logic        clr = 1'b0;
    logic [31:0] digits, op_value, hdigits, hop_value;
    logic [7:0]  digit_en, hdigit_en;
    logic [3:0]  count, op_code, hcount, hop_code;
    logic        op_valid, overflow, hop_valid, hoverflow;

    int checks = 0;
    int errors = 0;

    key_digit_entry #(.NUM_DIGITS(8), .HEX_MODE(1'b0)) dut (
        .clk(clk), .rst(rst), .key_pulse(key_pulse), .clr(clr),
        .digits(digits), .digit_en(digit_en), .count(count),
        .op_valid(op_valid), .op_code(op_code), .op_value(op_value), .overflow(overflow)
    );

    key_digit_entry #(.NUM_DIGITS(8), .HEX_MODE(1'b1)) hdut (
        .clk(clk), .rst(rst), .key_pulse(hkey), .clr(1'b0),
        .digits(hdigits), .digit_en(hdigit_en), .count(hcount),
        .op_valid(hop_valid), .op_code(hop_code), .op_value(hop_value), .overflow(hoverflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] key;
        logic        clr;
        logic [31:0] dg;
        logic [3:0]  cnt;
        logic        ovf;
        logic        opv;
        logic [3:0]  opc;
        logic [31:0] opval;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [15:0] k(input int code);
        logic [15:0] r;
        r = '0;
        r[(code == 0) ? 15 : code - 1] = 1'b1;
        return r;
    endfunction

    function automatic logic [7:0] exp_en(input logic [3:0] c);
`ifdef KDE_LZ_BLANK_EN
        logic [8:0] m;
        m = (c == 4'd0) ? 9'd1 : ((9'd1 << c) - 9'd1);
        return m[7:0];
`else
        return (c == c) ? 8'hFF : 8'h00;
`endif
    endfunction

    task automatic add(input logic [15:0] key, input logic c, input logic [31:0] dg,
                       input logic [3:0] cnt, input logic ovf, input logic opv,
                       input logic [3:0] opc, input logic [31:0] opval);
        vec_t v;
        v.key = key; v.clr = c; v.dg = dg; v.cnt = cnt;
        v.ovf = ovf; v.opv = opv; v.opc = opc; v.opval = opval;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Called on a negedge; holds the inputs for exactly one rising edge.
    task automatic apply(input logic [15:0] key, input logic c);
        key_pulse = key;
        clr = c;
        @(negedge clk);
        key_pulse = '0;
        clr = 1'b0;
    endtask

    task automatic happly(input logic [15:0] key);
        hkey = key;
        @(negedge clk);
        hkey = '0;
    endtask

    initial begin
        // key, clr, digits, count, ovf, opv, op_code, op_value
        add(k(1), 0, 32'h1, 1, 0, 0, 0, 0);
        add(k(2), 0, 32'h12, 2, 0, 0, 0, 0);
        add(k(3), 0, 32'h123, 3, 0, 0, 0, 0);
        add(16'h0, 1, 32'h0, 0, 0, 0, 0, 0);
        add(k(0), 0, 32'h0, 0, 0, 0, 0, 0);
        add(k(0), 0, 32'h0, 0, 0, 0, 0, 0);
        add(k(0), 0, 32'h0, 0, 0, 0, 0, 0);
        add(k(5), 0, 32'h5, 1, 0, 0, 0, 0);
        add(k(12), 0, 32'h0, 0, 0, 0, 0, 0);
        add(k(1), 0, 32'h1, 1, 0, 0, 0, 0);
        add(k(2), 0, 32'h12, 2, 0, 0, 0, 0);
        add(k(3), 0, 32'h123, 3, 0, 0, 0, 0);
        add(k(4), 0, 32'h1234, 4, 0, 0, 0, 0);
        add(k(5), 0, 32'h12345, 5, 0, 0, 0, 0);
        add(k(6), 0, 32'h123456, 6, 0, 0, 0, 0);
        add(k(7), 0, 32'h1234567, 7, 0, 0, 0, 0);
        add(k(8), 0, 32'h12345678, 8, 0, 0, 0, 0);
        add(k(9), 0, 32'h12345678, 8, 1, 0, 0, 0);
        add(16'h0, 0, 32'h12345678, 8, 0, 0, 0, 0);
        add(k(13), 0, 32'h01234567, 7, 0, 0, 0, 0);
        add(k(12), 0, 32'h0, 0, 0, 0, 0, 0);
        add(k(13), 0, 32'h0, 0, 0, 0, 0, 0);
        add(k(4), 0, 32'h4, 1, 0, 0, 0, 0);
        add(k(2), 0, 32'h42, 2, 0, 0, 0, 0);
        add(k(10), 0, 32'h42, 2, 0, 1, 4'hA, 32'h42);
        add(k(7), 0, 32'h7, 1, 0, 0, 4'hA, 32'h42);
        add(k(12), 0, 32'h0, 0, 0, 0, 4'hA, 32'h42);
        add(k(9), 0, 32'h9, 1, 0, 0, 4'hA, 32'h42);
        add(16'h0003, 0, 32'h9, 1, 0, 0, 4'hA, 32'h42);
        add(16'h0001, 1, 32'h0, 0, 0, 0, 4'hA, 32'h42);
        add(k(3), 0, 32'h3, 1, 0, 0, 4'hA, 32'h42);
        add(k(11), 0, 32'h3, 1, 0, 1, 4'hB, 32'h3);
        add(k(15), 0, 32'h3, 1, 0, 1, 4'hF, 32'h3);
        add(k(13), 0, 32'h3, 1, 0, 0, 4'hF, 32'h3);
        add(k(0), 0, 32'h0, 0, 0, 0, 4'hF, 32'h3);
        add(k(6), 0, 32'h6, 1, 0, 0, 4'hF, 32'h3);
        add(k(14), 0, 32'h6, 1, 0, 1, 4'hE, 32'h6);
        add(k(8), 0, 32'h8, 1, 0, 0, 4'hE, 32'h6);

        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_digits", digits, 32'h0);
        chk("rst_count", {28'h0, count}, 32'h0);
        chk("rst_op", {op_valid, overflow, op_code}, 32'h0);
        chk("rst_op_value", op_value, 32'h0);
        chk("rst_digit_en", {24'h0, digit_en}, {24'h0, exp_en(4'd0)});

        foreach (vecs[i]) begin
            apply(vecs[i].key, vecs[i].clr);
            chk($sformatf("v%0d_digits", i), digits, vecs[i].dg);
            chk($sformatf("v%0d_count", i), {28'h0, count}, {28'h0, vecs[i].cnt});
            chk($sformatf("v%0d_overflow", i), {31'h0, overflow}, {31'h0, vecs[i].ovf});
            chk($sformatf("v%0d_op_valid", i), {31'h0, op_valid}, {31'h0, vecs[i].opv});
            chk($sformatf("v%0d_op_code", i), {28'h0, op_code}, {28'h0, vecs[i].opc});
            chk($sformatf("v%0d_op_value", i), op_value, vecs[i].opval);
            chk($sformatf("v%0d_digit_en", i), {24'h0, digit_en}, {24'h0, exp_en(vecs[i].cnt)});
        end
        chk("dig123_en", {24'h0, exp_en(4'd3)},
`ifdef KDE_LZ_BLANK_EN
            32'h07);
`else
            32'hFF);
`endif

        // Async reset in the middle of a cycle, with no clock edge in between.
        apply(k(12), 0);
        for (int d = 1; d <= 5; d++) apply(k(d), 0);
        chk("pre_rst_digits", digits, 32'h12345);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_digits", digits, 32'h0);
        chk("async_rst_count", {28'h0, count}, 32'h0);
        chk("async_rst_op", op_value, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Hex instance: every key is a digit, including A and C.
        happly(k(10));
        chk("hex_A_digits", hdigits, 32'hA);
        chk("hex_A_count", {28'h0, hcount}, 32'h1);
        happly(k(0));
        chk("hex_0_digits", hdigits, 32'hA0);
        happly(k(12));
        chk("hex_C_digits", hdigits, 32'hA0C);
        chk("hex_C_count", {28'h0, hcount}, 32'h3);
        chk("hex_no_op", {31'h0, hop_valid}, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end
endmodule
